// File: rtl/cdc_sync_filter.sv
// Multi-channel destination-side synchroniser with a per-channel stability
// filter and registered rise/fall event pulses. One clock (clk_dest), with a
// synchronous active-high reset.

// Per-channel stability filter: dout follows s only after s has differed
// from dout for FILTER_LEN consecutive cycles.
module cdc_sync_filter_lane #(
  parameter int FILTER_LEN = 4,
  parameter bit RST_VAL    = 1'b0
) (
  input  logic clk_dest,
  input  logic rst_dest,
  input  logic s,
  output logic dout,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] cnt;

  // Count disagreement cycles; commit the new level and pulse on the last one.
  always_ff @(posedge clk_dest) begin
    if (rst_dest) begin
      cnt  <= '0;
      dout <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        dout <= s;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module cdc_sync_filter #(
  parameter int                   NUM_SYNC_STAGES = 2,
  parameter int                   DATA_WIDTH      = 1,
  parameter int                   FILTER_LEN      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                  clk_dest,
  input  logic                  rst_dest,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  changed
);
  // Last synchroniser stage (or raw din when no CDC stages are built).
  logic [DATA_WIDTH-1:0] s;

  if (NUM_SYNC_STAGES > 0) begin : g_sync
    (* ASYNC_REG = "TRUE" *) logic [NUM_SYNC_STAGES-1:0][DATA_WIDTH-1:0] stg;

    // Plain flop chain; only stg[0] ever samples the asynchronous input.
    always_ff @(posedge clk_dest) begin
      if (rst_dest) begin
        stg <= {NUM_SYNC_STAGES{RESET_VALUE}};
      end else begin
        stg[0] <= din;
        for (int i = 1; i < NUM_SYNC_STAGES; i++) stg[i] <= stg[i-1];
      end
    end

    assign s = stg[NUM_SYNC_STAGES-1];
  end else begin : g_nosync
    assign s = din;
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    cdc_sync_filter_lane #(
      .FILTER_LEN (FILTER_LEN),
      .RST_VAL    (RESET_VALUE[i])
    ) u_lane (
      .clk_dest (clk_dest),
      .rst_dest (rst_dest),
      .s        (s[i]),
      .dout     (dout[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  // Any channel pulsing this cycle; driven purely from registered pulses.
  assign changed = |(rise | fall);
endmodule

// File: tb/tb_cdc_sync_filter.sv
// Scoreboard bench: stimulus pushes expected events (edge, dout, rise, fall);
// per-DUT monitors pop and compare whenever a DUT presents an event.
module tb_cdc_sync_filter;
  typedef struct {
    int         at;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [3:0] din, din_b;
  logic [3:0] dout, rise, fall, dout_b, rise_b, fall_b;
  logic       changed, changed_b;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  bit mon_a = 1'b0, mon_b = 1'b0;
  ev_t q_a[$];
  ev_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  cdc_sync_filter #(
    .NUM_SYNC_STAGES (2), .DATA_WIDTH (4), .FILTER_LEN (4), .RESET_VALUE (4'h0)
  ) dut_a (
    .clk_dest (clk), .rst_dest (rst), .din (din),
    .dout (dout), .rise (rise), .fall (fall), .changed (changed)
  );

  cdc_sync_filter #(
    .NUM_SYNC_STAGES (0), .DATA_WIDTH (4), .FILTER_LEN (1), .RESET_VALUE (4'hA)
  ) dut_b (
    .clk_dest (clk), .rst_dest (rst_b), .din (din_b),
    .dout (dout_b), .rise (rise_b), .fall (fall_b), .changed (changed_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Event packed as {edge, dout, rise, fall, changed}.
  task automatic check_event(input string name, inout ev_t q[$], input logic [3:0] d,
                             input logic [3:0] r, input logic [3:0] f, input logic c);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_unexpected: dout=%h rise=%h fall=%h changed=%b at edge %0d",
               name, d, r, f, c, edge_n);
    end else begin
      e = q.pop_front();
      chk(name, {edge_n[15:0], d, r, f, c}, {e.at[15:0], e.dout, e.rise, e.fall, 1'b1});
    end
  endtask

  // Monitor A: any pulse or changed flag is an event to be matched.
  always @(negedge clk)
    if (mon_a && (changed !== 1'b0 || rise !== 4'h0 || fall !== 4'h0))
      check_event("evt_a", q_a, dout, rise, fall, changed);

  // Monitor B: same for the zero-stage, unfiltered corner build.
  always @(negedge clk)
    if (mon_b && (changed_b !== 1'b0 || rise_b !== 4'h0 || fall_b !== 4'h0))
      check_event("evt_b", q_b, dout_b, rise_b, fall_b, changed_b);

  task automatic drive_a(input logic [3:0] v);
    @(negedge clk);
    din = v;
  endtask

  task automatic expect_a(input int dly, input logic [3:0] d, input logic [3:0] r,
                          input logic [3:0] f);
    q_a.push_back('{edge_n + dly, d, r, f});
  endtask

  task automatic drive_b(input logic [3:0] v, input logic [3:0] r, input logic [3:0] f);
    @(negedge clk);
    din_b = v;
    q_b.push_back('{edge_n + 1, v, r, f});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    din = 4'hF; din_b = 4'hA;
    idle(4);
    // Reset state with din held high.
    chk("rst_dout", {28'h0, dout}, 32'h0);
    chk("rst_pulses", {24'h0, rise, fall}, 32'h0);
    chk("rst_changed", {31'h0, changed}, 32'h0);
    chk("rst_dout_b", {28'h0, dout_b}, 32'hA);

    // Release: dout converges to F six edges later with a rise pulse.
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    mon_a = 1'b1; mon_b = 1'b1;
    expect_a(6, 4'hF, 4'hF, 4'h0);
    idle(5);
    chk("pre_conv_dout", {28'h0, dout}, 32'h0);
    idle(5);

    drive_a(4'h0); expect_a(6, 4'h0, 4'h0, 4'hF); idle(10);
    // Single channel rise then fall.
    drive_a(4'h1); expect_a(6, 4'h1, 4'h1, 4'h0); idle(10);
    drive_a(4'h0); expect_a(6, 4'h0, 4'h0, 4'h1); idle(10);

    // 3-cycle glitch on channel 1 is rejected.
    drive_a(4'h2); idle(2);
    drive_a(4'h0); idle(10);
    chk("glitch3_dout", {28'h0, dout}, 32'h0);

    // 4-cycle pulse is accepted; dout high for exactly 4 cycles.
    drive_a(4'h2); expect_a(6, 4'h2, 4'h2, 4'h0); expect_a(10, 4'h0, 4'h0, 4'h2);
    idle(3);
    drive_a(4'h0); idle(10);

    // Simultaneous channels.
    drive_a(4'h5); expect_a(6, 4'h5, 4'h5, 4'h0); idle(10);
    drive_a(4'hA); expect_a(6, 4'hA, 4'hA, 4'h5); idle(10);

    // Reset mid-filter: dout cleared without pulses, then reconverges to E.
    drive_a(4'hE); idle(1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_dout", {28'h0, dout}, 32'h0);
    chk("midrst_pulses", {24'h0, rise, fall}, 32'h0);
    expect_a(6, 4'hE, 4'hE, 4'h0);
    idle(5);
    chk("midrst_hold", {28'h0, dout}, 32'h0);
    idle(5);
    chk("midrst_final", {28'h0, dout}, 32'hE);

    // Corner build: one-edge latency, pulses on every changed bit.
    drive_b(4'h5, 4'h5, 4'hA); idle(2);
    drive_b(4'hF, 4'hA, 4'h0); idle(2);
    drive_b(4'h0, 4'h0, 4'hF);
    drive_b(4'h6, 4'h6, 4'h0); idle(2);
    chk("b_follow", {28'h0, dout_b}, 32'h6);

    idle(4);
    chk("q_a_empty", q_a.size(), 32'd0);
    chk("q_b_empty", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
